fpu_mul_pipe: RTL and testbench

Parametrised, 3-stage pipelined IEEE-style floating-point multiplier for the FPU datapath. Defaults to bfloat16 (NEXP=8, NSIG=7) and generalises to any NEXP/NSIG.
Adds what the combinational multiplier lacks:
- valid/ready handshake with backpressure
- four selectable rounding modes
- full subnormal input/output handling
- per-result exception flags plus sticky accumulated flags

---
 rtl/fpu_mul_pipe.sv | 177 +++++++++++++++++
 tb/tb_fpu_mul_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_pipe.sv
// fpu_mul_pipe: 3-stage pipelined IEEE-style multiplier with handshake, rounding modes, subnormals and flags
module fpu_mul_pipe #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NEXP+NSIG:0]       a,
  input  logic [NEXP+NSIG:0]       b,
  input  logic [1:0]               rmode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NEXP+NSIG:0]       p,
  output logic [5:0]               bfFlags,
  output logic [3:0]               exception,
  output logic [3:0]               flags_sticky,
  input  logic                     flags_clr
);
  localparam int W = NEXP + NSIG + 1;
  localparam int EW = NEXP + 2;
  localparam int MW = NSIG + 1;
  localparam int PW = 2 * MW;
  localparam int LW = $clog2(MW + 1);
  localparam int SHW = $clog2(NSIG + 3);
  localparam int BIAS = (1 << (NEXP - 1)) - 1;
  localparam logic [NEXP-1:0] EONES = '1;
  localparam logic [NEXP-1:0] EMAXF = NEXP'((1 << NEXP) - 2);
  localparam logic [NSIG-1:0] ZFRAC = '0;
  localparam logic [NSIG-1:0] QFRAC = NSIG'(1 << (NSIG - 1));
  localparam logic signed [EW-1:0] ONE = 1;
  localparam logic signed [EW-1:0] EMAX = (1 << NEXP) - 1;
  localparam logic [1:0] RNE = 2'd0, RUP = 2'd2, RDN = 2'd3;
  typedef enum logic [1:0] {S_FIN, S_ZERO, S_INF, S_NAN} spec_e;

  function automatic logic [LW-1:0] lzc(input logic [MW-1:0] v);
    lzc = '0;
    for (int i = 0; i < MW; i++) if (v[i]) lzc = LW'(MW - 1 - i);
  endfunction

  logic en;
  assign en = !out_valid || out_ready;
  assign in_ready = en;

  logic sa, sb;
  logic [NEXP-1:0] ea, eb, ea_eff, eb_eff;
  logic [NSIG-1:0] fa, fb;
  logic za, zb, ia, ib, na, nb, sna, snb;
  logic [MW-1:0] siga, sigb, ma_d, mb_d;
  logic [LW-1:0] sha, shb;
  logic signed [EW-1:0] esum_d;
  spec_e sp_d;
  logic inv_d;
  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  always_comb begin
    za = ea == '0 && fa == '0;
    zb = eb == '0 && fb == '0;
    ia = ea == EONES && fa == '0;
    ib = eb == EONES && fb == '0;
    na = ea == EONES && fa != '0;
    nb = eb == EONES && fb != '0;
    sna = na && !fa[NSIG-1];
    snb = nb && !fb[NSIG-1];
    siga = {ea != '0, fa};
    sigb = {eb != '0, fb};
    sha = ea == '0 ? lzc(siga) : '0;
    shb = eb == '0 ? lzc(sigb) : '0;
    ma_d = siga << sha;
    mb_d = sigb << shb;
    ea_eff = ea == '0 ? NEXP'(1) : ea;
    eb_eff = eb == '0 ? NEXP'(1) : eb;
    // biased product exponent; subnormals count as emin minus their normalising shift
    esum_d = EW'(ea_eff) + EW'(eb_eff) - EW'(BIAS) - EW'(sha) - EW'(shb);
    sp_d = (na || nb || (ia && zb) || (za && ib)) ? S_NAN : (ia || ib) ? S_INF : (za || zb) ? S_ZERO : S_FIN;
    inv_d = sna || snb || (ia && zb) || (za && ib);
  end

  logic v1_q, sg1_q, inv1_q, v2_q, sg2_q, inv2_q;
  logic signed [EW-1:0] e1_q, e2_q;
  logic [MW-1:0] ma1_q, mb1_q;
  logic [PW-1:0] pr2_q;
  spec_e sp1_q, sp2_q;
  logic [1:0] rm1_q, rm2_q;

  logic signed [EW-1:0] e_n, e_f;
  logic [EW-1:0] shv;
  logic [SHW-1:0] sh;
  logic [PW-1:0] m, sft;
  logic [MW-1:0] kept;
  logic [MW:0] rnd;
  logic tiny, lost, g, st, inexact, inc, ovf, to_inf;
  logic [W-1:0] p_fin, p_d;
  logic [NEXP-1:0] pe;
  logic [NSIG-1:0] pf;
  logic [5:0] bf_d;
  logic [3:0] exc_d, sticky_d;
  always_comb begin
    e_n = e2_q + EW'(pr2_q[PW-1]);
    m = pr2_q[PW-1] ? pr2_q : pr2_q << 1;
    tiny = e_n < ONE;
    shv = ONE - e_n;
    sh = !tiny ? '0 : (shv > EW'(NSIG + 2)) ? SHW'(NSIG + 2) : shv[SHW-1:0];
    sft = m >> sh;
    lost = |(m & ~({PW{1'b1}} << sh));
    kept = sft[PW-1 -: MW];
    g = sft[NSIG];
    st = |sft[NSIG-1:0] || lost;
    inexact = g || st;
    inc = rm2_q == RNE ? g && (st || kept[0]) : rm2_q == RUP ? !sg2_q && inexact : rm2_q == RDN ? sg2_q && inexact : 1'b0;
    rnd = {1'b0, kept} + (MW + 1)'(inc);
    // a subnormal rounding into the hidden bit lands on the minimum normal exponent
    e_f = tiny ? EW'(rnd[NSIG]) : e_n + EW'(rnd[MW]);
    ovf = e_f >= EMAX;
    to_inf = rm2_q == RNE || (rm2_q == RUP && !sg2_q) || (rm2_q == RDN && sg2_q);
    p_fin = ovf ? (to_inf ? {sg2_q, EONES, ZFRAC} : {sg2_q, EMAXF, ~ZFRAC}) : {sg2_q, e_f[NEXP-1:0], rnd[NSIG-1:0]};
    p_d = sp2_q == S_NAN ? {1'b0, EONES, QFRAC} : sp2_q == S_INF ? {sg2_q, EONES, ZFRAC} :
          sp2_q == S_ZERO ? {sg2_q, {(W-1){1'b0}}} : p_fin;
    exc_d = sp2_q == S_NAN ? {inv2_q, 3'b0} : sp2_q == S_FIN ? {1'b0, ovf, tiny && inexact, inexact || ovf} : 4'b0;
    pe = p_d[W-2 -: NEXP];
    pf = p_d[NSIG-1:0];
    bf_d = pe == EONES ? (pf == '0 ? 6'b001000 : pf[NSIG-1] ? 6'b010000 : 6'b100000) :
           pe == '0 ? (pf == '0 ? 6'b000001 : 6'b000010) : 6'b000100;
    sticky_d = (flags_clr ? 4'b0 : flags_sticky) | ((out_valid && out_ready) ? exception : 4'b0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      sg1_q <= 1'b0;
      inv1_q <= 1'b0;
      e1_q <= '0;
      ma1_q <= '0;
      mb1_q <= '0;
      sp1_q <= S_FIN;
      rm1_q <= '0;
      v2_q <= 1'b0;
      sg2_q <= 1'b0;
      inv2_q <= 1'b0;
      e2_q <= '0;
      pr2_q <= '0;
      sp2_q <= S_FIN;
      rm2_q <= '0;
      out_valid <= 1'b0;
      p <= '0;
      bfFlags <= '0;
      exception <= '0;
      flags_sticky <= '0;
    end else begin
      if (en) begin
        v1_q <= in_valid;
        sg1_q <= sa ^ sb;
        inv1_q <= inv_d;
        e1_q <= esum_d;
        ma1_q <= ma_d;
        mb1_q <= mb_d;
        sp1_q <= sp_d;
        rm1_q <= rmode;
        v2_q <= v1_q;
        sg2_q <= sg1_q;
        inv2_q <= inv1_q;
        e2_q <= e1_q;
        pr2_q <= ma1_q * mb1_q;
        sp2_q <= sp1_q;
        rm2_q <= rm1_q;
        out_valid <= v2_q;
      end
      if (en && v2_q) begin
        p <= p_d;
        bfFlags <= bf_d;
        exception <= exc_d;
      end
      flags_sticky <= sticky_d;
    end
  end
endmodule

// File: tb/tb_fpu_mul_pipe.sv
// tb_fpu_mul_pipe: scoreboard bench for fpu_mul_pipe (bfloat16 defaults) with directed vectors
module tb_fpu_mul_pipe;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, flags_clr = 1'b0;
  logic [15:0] a = '0, b = '0, p;
  logic [1:0] rmode = '0;
  logic [5:0] bfFlags;
  logic [3:0] exception, flags_sticky;
  int n_chk = 0, n_err = 0, cyc = 0;
  bit lat_en = 1'b0, drv_done, held = 1'b0;
  logic [25:0] hp;

  typedef struct {
    logic [15:0] p;
    logic [5:0] bf;
    logic [3:0] exc;
    int cyc;
    bit lat;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  typedef struct {
    logic [15:0] a, b;
    logic [1:0] rm;
    logic [15:0] p;
    logic [5:0] bf;
    logic [3:0] exc;
  } vec_t;
  vec_t tv[20] = '{
    '{16'h3F80, 16'h4000, 2'd0, 16'h4000, 6'h04, 4'h0},
    '{16'h4040, 16'h4040, 2'd0, 16'h4110, 6'h04, 4'h0},
    '{16'h3F81, 16'h3F81, 2'd0, 16'h3F82, 6'h04, 4'h1},
    '{16'h3F81, 16'h3F81, 2'd2, 16'h3F83, 6'h04, 4'h1},
    '{16'h3F81, 16'h3F81, 2'd1, 16'h3F82, 6'h04, 4'h1},
    '{16'h7F7F, 16'h4000, 2'd0, 16'h7F80, 6'h08, 4'h5},
    '{16'h7F7F, 16'h4000, 2'd1, 16'h7F7F, 6'h04, 4'h5},
    '{16'hFF7F, 16'h4000, 2'd2, 16'hFF7F, 6'h04, 4'h5},
    '{16'h7F7F, 16'h4000, 2'd3, 16'h7F7F, 6'h04, 4'h5},
    '{16'hFF7F, 16'h4000, 2'd3, 16'hFF80, 6'h08, 4'h5},
    '{16'h7F80, 16'h0000, 2'd0, 16'h7FC0, 6'h10, 4'h8},
    '{16'hFF80, 16'h4000, 2'd0, 16'hFF80, 6'h08, 4'h0},
    '{16'h0080, 16'h3F00, 2'd0, 16'h0040, 6'h02, 4'h0},
    '{16'h0001, 16'h3F00, 2'd0, 16'h0000, 6'h01, 4'h3},
    '{16'h0001, 16'h3F00, 2'd2, 16'h0001, 6'h02, 4'h3},
    '{16'h0080, 16'h3F7F, 2'd0, 16'h0080, 6'h04, 4'h3},
    '{16'h7F81, 16'h3F80, 2'd0, 16'h7FC0, 6'h10, 4'h8},
    '{16'h8000, 16'h4000, 2'd0, 16'h8000, 6'h01, 4'h0},
    '{16'h3F81, 16'h3F81, 2'd3, 16'h3F82, 6'h04, 4'h1},
    '{16'hBF81, 16'h3F81, 2'd2, 16'hBF82, 6'h04, 4'h1}
  };

  fpu_mul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .rmode(rmode),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .bfFlags(bfFlags), .exception(exception),
    .flags_sticky(flags_sticky), .flags_clr(flags_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic issue(input logic [15:0] ia, ib, input logic [1:0] rm, input logic [15:0] ep,
                       input logic [5:0] ebf, input logic [3:0] ee);
    int n = 0;
    a = ia;
    b = ib;
    rmode = rm;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    sb.push_back('{ep, ebf, ee, cyc, lat_en});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      n++;
      @(negedge clk);
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) held = 1'b0;
    else begin
      if (held && out_valid) chk("hold", {bfFlags, exception, p}, hp);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          e = sb.pop_front();
          chk("p", p, e.p);
          chk("bfFlags", bfFlags, e.bf);
          chk("exception", exception, e.exc);
          if (e.lat) chk("latency", cyc - e.cyc, 3);
        end
      end
      held = out_valid && !out_ready;
      hp = {bfFlags, exception, p};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {p, bfFlags, exception, flags_sticky}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 lat_en = 1'b1;
    foreach (tv[i]) issue(tv[i].a, tv[i].b, tv[i].rm, tv[i].p, tv[i].bf, tv[i].exc);
    drain();
    lat_en = 1'b0;
    flags_clr = 1'b1;
    @(posedge clk);
    #1 flags_clr = 1'b0;
    @(negedge clk);
    chk("sticky_clr", flags_sticky, 0);
    @(posedge clk);
    #1;
    issue(16'h7F7F, 16'h4000, 2'd0, 16'h7F80, 6'h08, 4'h5);
    issue(16'h3F81, 16'h3F81, 2'd0, 16'h3F82, 6'h04, 4'h1);
    drain();
    chk("sticky_accum", flags_sticky, 4'b0101);
    issue(16'h7F80, 16'h0000, 2'd0, 16'h7FC0, 6'h10, 4'h8);
    begin
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("clr_wait", out_valid, 1);
    end
    flags_clr = 1'b1;
    @(posedge clk);
    #1 flags_clr = 1'b0;
    @(negedge clk);
    chk("sticky_clr_hs", flags_sticky, 4'b1000);
    drain();
    out_ready = 1'b0;
    drv_done = 1'b0;
    fork
      begin
        issue(16'h3F80, 16'h4000, 2'd0, 16'h4000, 6'h04, 4'h0);
        issue(16'h4040, 16'h4040, 2'd0, 16'h4110, 6'h04, 4'h0);
        issue(16'h3F80, 16'h4040, 2'd0, 16'h4040, 6'h04, 4'h0);
        issue(16'h4000, 16'h4000, 2'd0, 16'h4080, 6'h04, 4'h0);
        issue(16'h3F80, 16'h3F80, 2'd0, 16'h3F80, 6'h04, 4'h0);
        drv_done = 1'b1;
      end
    join_none
    repeat (6) @(negedge clk);
    chk("bp_accepts", sb.size(), 3);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    begin
      int n = 0;
      while (!drv_done && n < 60) begin
        n++;
        @(posedge clk);
      end
      chk("bp_driver_done", drv_done, 1);
    end
    drain();
    issue(16'h3F80, 16'h4000, 2'd0, 16'h4000, 6'h04, 4'h0);
    issue(16'h4040, 16'h4040, 2'd0, 16'h4110, 6'h04, 4'h0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_outputs", {p, bfFlags, exception, flags_sticky}, 0);
    end
    chk("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
